sd_block_reader: RTL and testbench
==================================

# sd_block_reader

Consumes bytes from the SPI byte receiver during an SD single-block read. It polls for the start token and streams the 512 data bytes out over a valid/ready interface. It then reads the 16-bit CRC and reports completion status. It sits between the SD command sequencer, which issues CMD17 and pulses `start`, and the spi_receiver, which it drives through `rx_en` and whose `rx_data`/`rx_done` it consumes.

## Interface
- `BLOCK_BYTES`, 512: data bytes per block.
- `TOKEN_TIMEOUT`, 1024: maximum 0xFF bytes polled before the token timeout fires.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request to read one block. Ignored unless `busy`=0.
- `rx_en` out 1: byte request to the receiver, one-cycle pulse.
- `rx_data` in 8: received byte, valid while `rx_done`=1 after a request.
- `rx_done` in 1: receiver idle/complete.
- `data_out` out 8: streamed block byte.
- `data_valid` out 1: `data_out` valid.
- `data_ready` in 1: consumer accepts the byte.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `timeout_err` out 1: no token within `TOKEN_TIMEOUT` bytes.
- `token_err` out 1: error token or an illegal token was received.
- `crc_err` out 1: CRC mismatch.

## Operation
- States: IDLE, TOK_REQ, TOK_WAIT, DAT_REQ, DAT_WAIT, DAT_OUT, CRC_REQ, CRC_WAIT, FINISH.
- IDLE:
  - On `start`, clear all three error flags and the CRC register, zero the counters, set `busy`, and go to TOK_REQ.
- Byte fetch (every *_REQ state):
  - Drive `rx_en`=1 for exactly that one cycle, then go to the matching *_WAIT state.
  - *_WAIT ignores `rx_done` in its first cycle. From the second cycle on, the first cycle with `rx_done`=1 samples `rx_data`.
- TOK_WAIT:
  - 0xFF: increment the poll count. If it reaches `TOKEN_TIMEOUT`, set `timeout_err` and go to FINISH; otherwise go to TOK_REQ.
  - 0xFE: go to DAT_REQ.
  - Any other value: set `token_err` and go to FINISH.
- DAT_WAIT:
  - Latch the byte into `data_out`, fold it into the CRC, and go to DAT_OUT.
- DAT_OUT:
  - Hold `data_valid`=1 with `data_out` stable until `data_ready`=1.
  - On the cycle of acceptance, increment the byte count. At `BLOCK_BYTES` go to CRC_REQ; otherwise go to DAT_REQ.
  - No new byte is requested while a byte is pending, which gives natural backpressure.
- CRC_REQ/CRC_WAIT:
  - Run twice, taking the high byte first and then the low byte. After the second byte, compare and go to FINISH.
- FINISH:
  - Pulse `done` for one cycle, clear `busy`, and return to IDLE.
- Error flags hold their value from FINISH until the next accepted `start`.
- Counter widths are `$clog2(BLOCK_BYTES+1)` and `$clog2(TOKEN_TIMEOUT+1)`. Counters do not wrap.
- Reset, including mid-operation:
  - State returns to IDLE and all outputs go to 0.
  - An in-flight receiver byte is abandoned. The receiver shares the same reset.

## Timing
- Reset values: `rx_en`=0, `data_out`=0x00, `data_valid`=0, `busy`=0, `done`=0, and all error flags 0.
- `busy` rises the cycle after `start`. `rx_en` first pulses two cycles after `start`.
- `data_valid` rises the cycle after the `rx_done` sample. The next `rx_en` follows the cycle after acceptance.
- `done` is asserted in the same cycle `busy` falls. Error flags are valid in that cycle.
- A `start` coincident with `done` is ignored.

## Configuration
- `SD_READ_CRC_EN` defined:
  - CRC16-CCITT (poly 0x1021, init 0x0000, MSB-first) is computed over the data bytes.
  - `crc_err` is set when the received CRC differs from the computed one.
- Undefined:
  - The two CRC bytes are still fetched and discarded.
  - `crc_err` is tied to 0 and no CRC logic is instantiated.

## Structure
- Shared package `sd_pkg` holds:
  - the state enum;
  - the `SD_TOKEN_START`=0xFE and `SD_IDLE_BYTE`=0xFF constants;
  - the CRC16 polynomial constant.
- One sub-module, `sd_crc16`, provides a byte-wide combinational next-CRC function with a registered accumulator and clear/enable inputs. It is instantiated only under `SD_READ_CRC_EN`.

## Test plan
- Three 0xFF bytes, then 0xFE, 512 bytes 0x00..0xFF repeating, and a correct CRC, with `data_ready` always high:
  - 512 ordered bytes are output;
  - `done` is asserted with all flags 0.
- Same block with `data_ready` toggling every 3 cycles:
  - identical data;
  - no `rx_en` while `data_valid`=1.
- 1024 consecutive 0xFF bytes:
  - `timeout_err`=1 and `done` is asserted;
  - exactly 1024 `rx_en` pulses;
  - no `data_valid`.
- Token 0x05:
  - `token_err`=1 and `done` is asserted after 1 byte;
  - no data output.
- Valid block with the last CRC byte flipped:
  - with the macro: `crc_err`=1;
  - without the macro: `crc_err`=0.
- Reset asserted at data byte 100:
  - all outputs return to reset values the next cycle;
  - a subsequent `start` reads a full block correctly.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD block-read path: FSM states, SD token
// constants and the CRC16-CCITT byte update used by sd_crc16.
package sd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TOK_REQ,
        TOK_WAIT,
        DAT_REQ,
        DAT_WAIT,
        DAT_OUT,
        CRC_REQ,
        CRC_WAIT,
        FINISH
    } sd_state_e;

    localparam logic [7:0]  SD_TOKEN_START = 8'hFE;
    localparam logic [7:0]  SD_IDLE_BYTE   = 8'hFF;
    localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;

    // One byte of CRC16-CCITT, MSB first: the byte is folded into the top
    // of the register and then shifted out bit by bit.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ SD_CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Byte-wide CRC16-CCITT accumulator (init 0x0000). clr wins over en.
// Only instantiated when SD_READ_CRC_EN is defined.
module sd_crc16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [15:0] crc
);
    import sd_pkg::*;

    // Accumulate one data byte per enabled cycle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= crc16_next(crc, data_in);
        end
    end

endmodule

// File: rtl/sd_block_reader.sv
// SD single-block reader: polls for the start token, streams the data
// bytes over valid/ready, then fetches the two CRC bytes.
// Optional feature macro: SD_READ_CRC_EN (CRC16 check of the data bytes).
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | waiting for start
// TOK_REQ  | request a token-poll byte
// TOK_WAIT | wait for the poll byte, classify it
// DAT_REQ  | request a data byte
// DAT_WAIT | wait for the data byte, latch it
// DAT_OUT  | hold the byte until the consumer accepts it
// CRC_REQ  | request a CRC byte (high first, then low)
// CRC_WAIT | wait for the CRC byte
// FINISH   | report completion
module sd_block_reader #(
    parameter int BLOCK_BYTES   = 512,
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       rx_en,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic       token_err,
    output logic       crc_err
);
    import sd_pkg::*;

    localparam int BW = $clog2(BLOCK_BYTES + 1);
    localparam int PW = $clog2(TOKEN_TIMEOUT + 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BLOCK_BYTES);
    localparam logic [PW-1:0] POLL_LAST = PW'(TOKEN_TIMEOUT);

    sd_state_e     state_q, state_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic          crc_hi_seen_q, crc_hi_seen_d;
    logic          rx_en_q, rx_en_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_valid_q, data_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_err_q, timeout_err_d;
    logic          token_err_q, token_err_d;
    logic          rx_sample;
`ifdef SD_READ_CRC_EN
    logic [7:0]    crc_hi_q, crc_hi_d;
    logic          crc_err_q, crc_err_d;
    logic          crc_clr, crc_en;
    logic [15:0]   crc_calc;
`endif

    // rx_en is registered, so it is high exactly during the first cycle of
    // every *_WAIT state; rx_done is ignored in that cycle because the
    // receiver has not yet seen the request.
    assign rx_sample = rx_done && !rx_en_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            poll_cnt_q    <= '0;
            crc_hi_seen_q <= 1'b0;
            rx_en_q       <= 1'b0;
            data_out_q    <= 8'h00;
            data_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            token_err_q   <= 1'b0;
`ifdef SD_READ_CRC_EN
            crc_hi_q      <= 8'h00;
            crc_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            poll_cnt_q    <= poll_cnt_d;
            crc_hi_seen_q <= crc_hi_seen_d;
            rx_en_q       <= rx_en_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            token_err_q   <= token_err_d;
`ifdef SD_READ_CRC_EN
            crc_hi_q      <= crc_hi_d;
            crc_err_q     <= crc_err_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        poll_cnt_d    = poll_cnt_q;
        crc_hi_seen_d = crc_hi_seen_q;
        rx_en_d       = 1'b0;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        token_err_d   = token_err_q;
`ifdef SD_READ_CRC_EN
        crc_hi_d      = crc_hi_q;
        crc_err_d     = crc_err_q;
        crc_clr       = 1'b0;
        crc_en        = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // done_q high means we just left FINISH; a start in that
                // cycle belongs to the old operation and is dropped.
                if (start && !done_q) begin
                    byte_cnt_d    = '0;
                    poll_cnt_d    = '0;
                    crc_hi_seen_d = 1'b0;
                    timeout_err_d = 1'b0;
                    token_err_d   = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = TOK_REQ;
`ifdef SD_READ_CRC_EN
                    crc_hi_d      = 8'h00;
                    crc_err_d     = 1'b0;
                    crc_clr       = 1'b1;
`endif
                end
            end
            TOK_REQ: begin
                rx_en_d = 1'b1;
                state_d = TOK_WAIT;
            end
            TOK_WAIT: begin
                if (rx_sample) begin
                    if (rx_data == SD_IDLE_BYTE) begin
                        poll_cnt_d = poll_cnt_q + PW'(1);
                        if (poll_cnt_d == POLL_LAST) begin
                            timeout_err_d = 1'b1;
                            state_d       = FINISH;
                        end else begin
                            state_d = TOK_REQ;
                        end
                    end else if (rx_data == SD_TOKEN_START) begin
                        state_d = DAT_REQ;
                    end else begin
                        token_err_d = 1'b1;
                        state_d     = FINISH;
                    end
                end
            end
            DAT_REQ: begin
                rx_en_d = 1'b1;
                state_d = DAT_WAIT;
            end
            DAT_WAIT: begin
                if (rx_sample) begin
                    data_out_d   = rx_data;
                    data_valid_d = 1'b1;
                    state_d      = DAT_OUT;
`ifdef SD_READ_CRC_EN
                    crc_en       = 1'b1;
`endif
                end
            end
            DAT_OUT: begin
                if (data_ready) begin
                    data_valid_d = 1'b0;
                    byte_cnt_d   = byte_cnt_q + BW'(1);
                    state_d      = (byte_cnt_d == BYTE_LAST) ? CRC_REQ : DAT_REQ;
                end
            end
            CRC_REQ: begin
                rx_en_d = 1'b1;
                state_d = CRC_WAIT;
            end
            CRC_WAIT: begin
                if (rx_sample) begin
                    if (!crc_hi_seen_q) begin
                        crc_hi_seen_d = 1'b1;
                        state_d       = CRC_REQ;
`ifdef SD_READ_CRC_EN
                        crc_hi_d      = rx_data;
`endif
                    end else begin
                        state_d = FINISH;
`ifdef SD_READ_CRC_EN
                        crc_err_d = ({crc_hi_q, rx_data} != crc_calc);
`endif
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef SD_READ_CRC_EN
    sd_crc16 u_crc (
        .clk     (clk),
        .reset   (reset),
        .clr     (crc_clr),
        .en      (crc_en),
        .data_in (rx_data),
        .crc     (crc_calc)
    );
    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

    assign rx_en       = rx_en_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign token_err   = token_err_q;

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: behavioural SPI receiver fed from a byte
// queue, scoreboard of expected data bytes, table of block scenarios plus
// hand-written reset/start-timing sequences.
module tb_sd_block_reader;

    typedef struct {
        int         n_ff;
        logic [7:0] token;
        int         ready_mode;
        int         lat;
        bit         bad_crc;
        bit         e_to;
        bit         e_tok;
        bit         e_crc;
        int         e_bytes;
        int         e_rx_en;
    } vec_t;

`ifdef SD_READ_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, rx_en, rx_done, data_valid, data_ready;
    logic       busy, done, timeout_err, token_err, crc_err;
    logic [7:0] rx_data, data_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int rx_en_cnt   = 0;
    int acc_cnt     = 0;
    int overlap_cnt = 0;
    int ready_mode  = 0;
    int lat         = 2;
    int phase       = 0;
    int pending     = 0;
    int rcnt        = 0;

    vec_t vecs[5];

    always #5 clk = ~clk;

    sd_block_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_en       (rx_en),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .token_err   (token_err),
        .crc_err     (crc_err)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Bitwise CRC16-CCITT reference (feedback form).
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    // Negedge process: consumer ready pattern, output monitor/scoreboard,
    // and the receiver model (latency lat cycles after an rx_en pulse).
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (ready_mode == 0) begin
                data_ready = 1'b1;
            end else begin
                phase++;
                if (phase % 3 == 0) data_ready = ~data_ready;
            end
            if (rx_en) rx_en_cnt++;
            if (rx_en && data_valid) overlap_cnt++;
            if (data_valid && data_ready) begin
                acc_cnt++;
                e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
                check("data_byte", int'(data_out), e);
            end
            if (reset) begin
                pending = 0;
                rx_done = 1'b1;
            end else if (pending != 0) begin
                rcnt--;
                if (rcnt <= 0) begin
                    rx_data = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
                    rx_done = 1'b1;
                    pending = 0;
                end
            end else if (rx_en) begin
                rx_done = 1'b0;
                pending = 1;
                rcnt    = lat;
            end
        end
    end

    task automatic load(input vec_t v);
        logic [15:0] c;
        logic [7:0]  b;
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < v.n_ff; i++) rx_q.push_back(8'hFF);
        rx_q.push_back(v.token);
        if (v.token == 8'hFE) begin
            c = 16'h0000;
            for (int i = 0; i < 512; i++) begin
                b = 8'(i);
                rx_q.push_back(b);
                exp_q.push_back(b);
                c = crc_model(c, b);
            end
            rx_q.push_back(c[15:8]);
            rx_q.push_back(v.bad_crc ? (c[7:0] ^ 8'h01) : c[7:0]);
        end
        ready_mode  = v.ready_mode;
        lat         = v.lat;
        rx_en_cnt   = 0;
        acc_cnt     = 0;
        overlap_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(posedge clk); #2;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", int'(ok), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_en"},       int'(rx_en), 0);
        check({tag, "_data_out"},    int'(data_out), 0);
        check({tag, "_data_valid"},  int'(data_valid), 0);
        check({tag, "_busy"},        int'(busy), 0);
        check({tag, "_done"},        int'(done), 0);
        check({tag, "_timeout_err"}, int'(timeout_err), 0);
        check({tag, "_token_err"},   int'(token_err), 0);
        check({tag, "_crc_err"},     int'(crc_err), 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        load(v);
        pulse_start();
        wait_done(ok);
        if (ok) begin
            check($sformatf("vec%0d_timeout_err", idx), int'(timeout_err), int'(v.e_to));
            check($sformatf("vec%0d_token_err", idx),   int'(token_err),   int'(v.e_tok));
            check($sformatf("vec%0d_crc_err", idx),     int'(crc_err),     int'(v.e_crc));
            check($sformatf("vec%0d_busy_at_done", idx), int'(busy), 0);
        end
        @(posedge clk); #2;
        check($sformatf("vec%0d_bytes_out", idx),  acc_cnt, v.e_bytes);
        check($sformatf("vec%0d_bytes_left", idx), exp_q.size(), 0);
        check($sformatf("vec%0d_rx_en_pulses", idx), rx_en_cnt, v.e_rx_en);
        check($sformatf("vec%0d_rx_en_while_valid", idx), overlap_cnt, 0);
    endtask

    initial begin
        bit ok;
        vec_t tok_vec;

        //          n_ff  token  rdy lat bad  to tok crc     bytes rx_en
        vecs[0] = '{3,    8'hFE, 0,  2,  0,   0, 0,  0,      512,  518};
        vecs[1] = '{3,    8'hFE, 1,  1,  0,   0, 0,  0,      512,  518};
        vecs[2] = '{1023, 8'hFF, 0,  1,  0,   1, 0,  0,      0,    1024};
        vecs[3] = '{0,    8'h05, 0,  2,  0,   0, 1,  0,      0,    1};
        vecs[4] = '{0,    8'hFE, 0,  3,  1,   0, 0,  CRC_ON, 512,  515};

        reset      = 1'b1;
        start      = 1'b0;
        data_ready = 1'b1;
        rx_done    = 1'b1;
        rx_data    = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #2;

        // Start timing and a start coincident with done.
        tok_vec = '{0, 8'h05, 0, 2, 0, 0, 1, 0, 0, 1};
        load(tok_vec);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("rx_en_one_after_start", int'(rx_en), 0);
        @(posedge clk); #2;
        check("rx_en_two_after_start", int'(rx_en), 1);
        wait_done(ok);
        check("seq_token_err", int'(token_err), 1);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("start_with_done_busy", int'(busy), 0);
        repeat (4) @(posedge clk);
        #2;
        check("start_with_done_rx_en", rx_en_cnt, 1);

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of the data phase, then a clean block.
        load(vecs[0]);
        pulse_start();
        for (int k = 0; k < 20000 && acc_cnt < 100; k++) begin
            @(posedge clk); #2;
        end
        check("midreset_reached_byte100", int'(acc_cnt >= 100), 1);
        reset = 1'b1;
        @(posedge clk); #2;
        check_idle_outputs("midreset");
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
        @(posedge clk); #2;
        run_vec(vecs[0], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
